// File: rtl/regfile_check_engine_if.sv
// Trace-stream bundle of regfile_check_engine: FIFO head, pop handshake and
// the sticky overflow flag. The engine drives the master side.
interface regfile_check_engine_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CYC_W  = 16
) ();
  logic              trace_valid;
  logic              trace_ready;
  logic [CYC_W-1:0]  trace_cycle;
  logic [REG_AW-1:0] trace_rd;
  logic [DATA_W-1:0] trace_data;
  logic              trace_overflow;

  modport master (
    output trace_valid, trace_cycle, trace_rd, trace_data, trace_overflow,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_cycle, trace_rd, trace_data, trace_overflow,
    output trace_ready
  );
endinterface

// File: rtl/regfile_check_engine.sv
// regfile_check_engine: lets the CPU run for num_cycles cycles while snooping
// register writes into a cycle-stamped trace FIFO, then takes over regfile
// read port A and compares every register against a loaded expected table.
// Optional feature macro: REGCHK_TRACE_EN builds the trace FIFO; without it
// the trace outputs are tied to 0 and trace_ready is ignored.
//
// state | meaning
// IDLE  | waiting for start, expected table writable
// RUN   | CPU free-running, writes snooped into the trace FIFO
// CHECK | CPU held, sweeping idx over all registers and comparing
// DONE  | results valid and held, table writable, start re-arms
module regfile_check_engine #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int CYC_W    = 16,
  parameter int TRACE_AW = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CYC_W-1:0]    num_cycles,
  input  logic                exp_we,
  input  logic [REG_AW-1:0]   exp_addr,
  input  logic [DATA_W-1:0]   exp_data,
  input  logic                cpu_rwe,
  input  logic [REG_AW-1:0]   cpu_rd,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [REG_AW-1:0]   cpu_rs1,
  output logic [REG_AW-1:0]   rf_rs1,
  input  logic [DATA_W-1:0]   rf_data_a,
  output logic                cpu_hold,
  regfile_check_engine_if.master trace,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [REG_AW:0]     err_count,
  output logic                first_fail_valid,
  output logic [REG_AW-1:0]   first_fail_reg
);
  localparam int NREGS = 2 ** REG_AW;
  localparam int ERR_W = REG_AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t            state;
  logic [CYC_W-1:0]  cnt;
  logic [CYC_W-1:0]  ncyc;
  logic [REG_AW-1:0] idx;
  logic [DATA_W-1:0] exp_mem [NREGS];

  logic idle_like, start_ok, mismatch;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_ok  = start && idle_like;
  assign rf_rs1    = (state == CHECK) ? idx : cpu_rs1;
  assign mismatch  = (rf_data_a != exp_mem[idx]);

  // Expected table: no reset so the contents survive reset and later runs.
  always_ff @(posedge clock) begin
    if (exp_we && idle_like) exp_mem[exp_addr] <= exp_data;
  end

  // Sequencer with registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      ncyc             <= '0;
      idx              <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_reg   <= '0;
      cpu_hold         <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt              <= '0;
            ncyc             <= num_cycles;
            idx              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_reg   <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            if (num_cycles == '0) begin
              state    <= CHECK;
              cpu_hold <= 1'b1;
            end else begin
              state    <= RUN;
              cpu_hold <= 1'b0;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CYC_W'(1);
          if (cnt == ncyc - CYC_W'(1)) begin
            state    <= CHECK;
            idx      <= '0;
            cpu_hold <= 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_reg   <= idx;
            end
          end
          idx <= idx + REG_AW'(1);
          if (&idx) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REGCHK_TRACE_EN
  localparam int DEPTH = 2 ** TRACE_AW;
  localparam int ENT_W = CYC_W + REG_AW + DATA_W;

  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [TRACE_AW:0] wr_ptr, rd_ptr, fill;
  logic              ovf, full, empty, push, pop, push_ok;

  assign fill    = wr_ptr - rd_ptr;
  assign full    = fill[TRACE_AW];
  assign empty   = (wr_ptr == rd_ptr);
  assign push    = (state == RUN) && cpu_rwe && (cpu_rd != '0);
  assign pop     = !empty && trace.trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop);

  // Pointer and overflow bookkeeping; a new run flushes the FIFO.
  always_ff @(posedge clock) begin
    if (!reset_n || start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (TRACE_AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (TRACE_AW+1)'(1);
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  // Trace storage write, entry = {cycle, rd, data}.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr[TRACE_AW-1:0]] <= {cnt, cpu_rd, cpu_wdata};
  end

  assign trace.trace_valid    = !empty;
  assign trace.trace_overflow = ovf;
  assign {trace.trace_cycle, trace.trace_rd, trace.trace_data} =
    fifo_mem[rd_ptr[TRACE_AW-1:0]];
`else
  logic unused_trace;
  assign unused_trace = ^{trace.trace_ready, cpu_rwe, cpu_rd, cpu_wdata};

  assign trace.trace_valid    = 1'b0;
  assign trace.trace_overflow = 1'b0;
  assign trace.trace_cycle    = '0;
  assign trace.trace_rd       = '0;
  assign trace.trace_data     = '0;
`endif
endmodule

// File: tb/tb_regfile_check_engine.sv
// Scoreboard bench for regfile_check_engine: stimulus pushes expected run
// results and trace entries; monitors pop and compare on done / trace pops.
module tb_regfile_check_engine;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int TAW = 4;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset_n, start, exp_we, cpu_rwe;
  logic [CW-1:0] num_cycles;
  logic [AW-1:0] exp_addr, cpu_rd, cpu_rs1, rf_rs1, first_fail_reg;
  logic [DW-1:0] exp_data, cpu_wdata, rf_data_a;
  logic          cpu_hold, busy, done, pass, first_fail_valid;
  logic [AW:0]   err_count;
  logic [DW-1:0] rf_model [NR];

  regfile_check_engine_if #(.DATA_W(DW), .REG_AW(AW), .CYC_W(CW)) tif ();

  regfile_check_engine #(.DATA_W(DW), .REG_AW(AW), .CYC_W(CW), .TRACE_AW(TAW)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .num_cycles(num_cycles),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .cpu_rs1(cpu_rs1), .rf_rs1(rf_rs1), .rf_data_a(rf_data_a),
    .cpu_hold(cpu_hold), .trace(tif.master), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail_valid(first_fail_valid),
    .first_fail_reg(first_fail_reg)
  );

  assign rf_data_a = rf_model[rf_rs1];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_cyc;
    logic       pass_e;
    logic [5:0] err_e;
    logic       ffv_e;
    logic [4:0] ffr_e;
  } res_t;

  typedef struct {
    logic [15:0] c;
    logic [4:0]  rd;
    logic [31:0] d;
  } tr_t;

  res_t res_q [$];
  tr_t  tr_q  [$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: compares each rising done against the oldest expectation.
  logic prev_done = 1'b0;
  initial forever begin
    @(negedge clk);
    if (done && !prev_done) begin
      if (res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("done_cycle", cyc, r.done_cyc);
        chk("pass", pass, r.pass_e);
        chk("err_count", err_count, r.err_e);
        chk("first_fail_valid", first_fail_valid, r.ffv_e);
        chk("first_fail_reg", first_fail_reg, r.ffr_e);
      end
    end
    prev_done = done;
  end

  // Trace monitor: every accepted pop must match the next expected entry.
  initial forever begin
    @(negedge clk);
    if (tif.trace_valid && tif.trace_ready) begin
      if (tr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_trace actual=%0h/%0h/%0h required=none",
                 tif.trace_cycle, tif.trace_rd, tif.trace_data);
      end else begin
        tr_t t;
        t = tr_q.pop_front();
        chk("trace_cycle", tif.trace_cycle, t.c);
        chk("trace_rd", tif.trace_rd, t.rd);
        chk("trace_data", tif.trace_data, t.d);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Pulses start; returns one cycle after the sampling edge (first RUN cycle).
  task automatic do_start(input int n, input bit push_res, input bit p,
                          input int e, input bit fv, input int fr);
    res_t r;
    step();
    start = 1'b1;
    num_cycles = CW'(n);
    if (push_res) begin
      r.done_cyc = cyc + 1 + n + NR;
      r.pass_e = p;
      r.err_e = 6'(e);
      r.ffv_e = fv;
      r.ffr_e = 5'(fr);
      res_q.push_back(r);
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_results();
    int t = 0;
    while (res_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    chk("result_queue_drained", res_q.size(), 0);
  endtask

  task automatic push_tr(input int c, input int rd, input int d);
    tr_t t;
    t.c = 16'(c);
    t.rd = 5'(rd);
    t.d = 32'(d);
    tr_q.push_back(t);
  endtask

  logic exp_ovf;

  initial begin
`ifdef REGCHK_TRACE_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    reset_n = 1'b0; start = 1'b0; num_cycles = '0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    cpu_rwe = 1'b0; cpu_rd = '0; cpu_wdata = '0; cpu_rs1 = 5'd9;
    tif.trace_ready = 1'b0;
    for (int r = 0; r < NR; r++) rf_model[r] = 32'(r * 3);
    repeat (3) step();

    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ffv", first_fail_valid, 0);
    chk("rst_ffr", first_fail_reg, 0);
    chk("rst_trace_valid", tif.trace_valid, 0);
    chk("rst_overflow", tif.trace_overflow, 0);
    chk("rst_rf_rs1", rf_rs1, 9);
    reset_n = 1'b1;

    for (int r = 0; r < NR; r++) begin
      exp_we = 1'b1; exp_addr = 5'(r); exp_data = 32'(r * 3);
      step();
    end
    exp_we = 1'b0;

    // Matching regfile; start and table writes during RUN must be ignored.
    cpu_rs1 = 5'd5;
    do_start(10, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        chk("run_busy", busy, 1);
        chk("run_cpu_hold", cpu_hold, 0);
        chk("run_rf_rs1", rf_rs1, 5);
      end
      if (k == 3) begin start = 1'b1; num_cycles = 16'd2; end
      if (k == 4) start = 1'b0;
      if (k == 5) begin exp_we = 1'b1; exp_addr = 5'd10; exp_data = 32'hdead; end
      if (k == 6) exp_we = 1'b0;
      step();
    end
    wait_results();
    repeat (3) step();
    chk("done_hold", done, 1);
    chk("pass_hold", pass, 1);

    // Two corrupted registers.
    rf_model[7] = 32'd99;
    rf_model[20] = 32'd5;
    do_start(5, 1'b1, 1'b0, 2, 1'b1, 7);
    wait_results();
    rf_model[7] = 32'd21;
    rf_model[20] = 32'd60;

    // One valid write and one to r0, drained as it arrives.
    tif.trace_ready = 1'b1;
`ifdef REGCHK_TRACE_EN
    push_tr(2, 3, 32'h55);
`endif
    do_start(8, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      cpu_rwe = (k == 2) || (k == 4);
      cpu_rd = (k == 2) ? 5'd3 : 5'd0;
      cpu_wdata = (k == 2) ? 32'h55 : 32'h1;
      if (k == 3) chk("trace_valid_after_push", tif.trace_valid, exp_ovf);
      step();
    end
    cpu_rwe = 1'b0; cpu_rd = '0; cpu_wdata = '0;
    wait_results();
    chk("trace_queue_empty_1", tr_q.size(), 0);

    // Fill to 16, push+pop at full, then overflow.
    tif.trace_ready = 1'b0;
`ifdef REGCHK_TRACE_EN
    for (int k = 0; k <= 16; k++) push_tr(k, k + 1, 32'h100 + k);
`endif
    do_start(24, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int k = 0; k < 24; k++) begin
      cpu_rwe = (k <= 20);
      cpu_rd = 5'(k + 1);
      cpu_wdata = 32'h100 + 32'(k);
      tif.trace_ready = (k == 16);
      if (k == 17) chk("no_ovf_push_pop_full", tif.trace_overflow, 0);
      if (k == 18) chk("ovf_after_drop", tif.trace_overflow, exp_ovf);
      step();
    end
    cpu_rwe = 1'b0; cpu_rd = '0; cpu_wdata = '0;
    wait_results();
    tif.trace_ready = 1'b1;
    for (int t = 0; t < 40 && tif.trace_valid; t++) step();
    chk("trace_queue_empty_2", tr_q.size(), 0);
    chk("trace_drained", tif.trace_valid, 0);
    chk("ovf_sticky", tif.trace_overflow, exp_ovf);

    // Zero-length run goes straight to CHECK.
    do_start(0, 1'b1, 1'b1, 0, 1'b0, 0);
    chk("zero_run_busy", busy, 1);
    chk("zero_run_cpu_hold", cpu_hold, 1);
    wait_results();

    // Reset in the middle of CHECK, then a run reusing the retained table.
    rf_model[3] = 32'd1;
    do_start(0, 1'b0, 1'b0, 0, 1'b0, 0);
    repeat (10) step();
    chk("midcheck_busy", busy, 1);
    chk("midcheck_err", err_count, 1);
    chk("midcheck_ffr", first_fail_reg, 3);
    reset_n = 1'b0;
    step();
    chk("rst2_busy", busy, 0);
    chk("rst2_err", err_count, 0);
    chk("rst2_ffv", first_fail_valid, 0);
    chk("rst2_done", done, 0);
    chk("rst2_cpu_hold", cpu_hold, 1);
    reset_n = 1'b1;
    rf_model[3] = 32'd9;
    do_start(3, 1'b1, 1'b1, 0, 1'b0, 0);
    wait_results();

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_check_engine.md
# regfile_check_engine

Parametrised hardware run-and-check harness for the processor and register file. It lets the CPU run for a programmed number of cycles and snoops every register write into a cycle-stamped trace FIFO. It then takes over register-file read port A, sweeps every register and compares each one against an internally loaded expected-value table. It reports pass/fail, the error count and the first failing register, so self-checking runs need no simulator-only file I/O.

## Interface
- `DATA_W`, 32, register data width
- `REG_AW`, 5, register address width; NREGS = 2**REG_AW
- `CYC_W`, 16, cycle counter / `num_cycles` width
- `TRACE_AW`, 4, trace FIFO address width; depth = 2**TRACE_AW
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  pulse; arms a run (sampled in IDLE or DONE only)
- `num_cycles`  in  CYC_W  run length, sampled with `start`
- `exp_we`, `exp_addr`, `exp_data`  in  1 / REG_AW / DATA_W  expected-table write port; accepted only in IDLE or DONE
- `cpu_rwe`, `cpu_rd`, `cpu_wdata`  in  1 / REG_AW / DATA_W  snooped regfile write port
- `cpu_rs1`  in  REG_AW  processor's read-port-A address
- `rf_rs1`  out  REG_AW  muxed read-port-A address to the regfile
- `rf_data_a`  in  DATA_W  regfile read-port-A data (combinational read)
- `cpu_hold`  out  1  freezes the processor whenever the state is not RUN
- `trace_valid`, `trace_ready`  out / in  1  trace pop handshake
- `trace_cycle`, `trace_rd`, `trace_data`  out  CYC_W / REG_AW / DATA_W  FIFO head
- `trace_overflow`  out  1  sticky; set when a write was dropped
- `busy`, `done`, `pass`  out  1  status
- `err_count`  out  REG_AW+1  mismatching registers
- `first_fail_valid`, `first_fail_reg`  out  1 / REG_AW  lowest failing register index

## Operation
- States: IDLE, RUN, CHECK, DONE.
- **IDLE/DONE + `start`:**
  - Clear the cycle counter, `err_count`, the first-fail fields and `trace_overflow`.
  - Flush the FIFO.
  - Latch `num_cycles`.
  - Go to RUN. If `num_cycles` == 0, go directly to CHECK.
- **RUN:**
  - `rf_rs1` = `cpu_rs1`.
  - Every cycle, if `cpu_rwe` && `cpu_rd` != 0, push {counter, `cpu_rd`, `cpu_wdata`}.
  - The counter increments each cycle. RUN exits to CHECK after exactly `num_cycles` cycles, i.e. the cycle in which counter == `num_cycles`−1 is the last.
- **CHECK:**
  - `rf_rs1` = idx, starting at 0.
  - Each cycle compare `rf_data_a` with exp[idx]. Register 0 is compared like every other register.
  - On mismatch, increment `err_count`. If this is the first mismatch, also set `first_fail_valid` and `first_fail_reg` = idx.
  - After idx == NREGS−1, go to DONE.
- **DONE:**
  - `done` = 1.
  - `pass` = (`err_count` == 0).
  - Results hold until the next `start` or reset.
- `busy` = RUN or CHECK. `pass` is 0 outside DONE.
- **Trace FIFO:**
  - First-word fall-through; pop on `trace_valid` && `trace_ready`.
  - The FIFO keeps draining in CHECK and DONE.
  - Push when full with no pop in the same cycle: drop the entry and set `trace_overflow`.
  - Simultaneous push and pop when full: both take effect; no overflow.
- **Expected table:** NREGS×DATA_W. It is not cleared by reset and retains its contents across runs.
- `exp_we` is ignored in RUN and CHECK.
- **Reset mid-operation:** next state is IDLE; counters, flags and the FIFO are cleared; the table is retained.

## Timing
- Reset values of outputs:
  - `cpu_hold`=1.
  - `busy`=`done`=`pass`=0.
  - `err_count`=0.
  - `first_fail_valid`=0, `first_fail_reg`=0.
  - `trace_valid`=0, `trace_overflow`=0.
  - `rf_rs1`=`cpu_rs1`.
- `start` sampled at edge E: `busy` and the deasserted `cpu_hold` are visible after E.
- `done` rises `num_cycles`+NREGS cycles after E.
- A snooped write appears on `trace_valid` the cycle after the push edge.
- The CHECK compare and the table read are combinational within the cycle; the `err_count` update is registered.
- `start` while busy is ignored.

## Configuration
- `REGCHK_TRACE_EN` defined: trace FIFO is built as described.
- `REGCHK_TRACE_EN` undefined:
  - No FIFO storage is instantiated.
  - `trace_valid`, `trace_overflow`, `trace_cycle`, `trace_rd` and `trace_data` are tied to 0.
  - `trace_ready` is ignored.
  - Run and check behaviour are unchanged.

## Test plan
- Load exp[r]=r*3 (exp[0]=0), regfile model holding the same values, `num_cycles`=10 → `done` at cycle 10+32 after `start`, `pass`=1, `err_count`=0.
- Same setup but regfile r7=99 and r20=5 → `err_count`=2, `first_fail_reg`=7, `pass`=0.
- RUN with writes (rd=3, data=0x55) at counter 2 and (rd=0, data=1) at counter 4, `trace_ready`=1 → exactly one entry {cycle=2, rd=3, data=0x55}.
- `trace_ready`=0, 20 writes with depth 16 → 16 entries retained, `trace_overflow`=1. With full FIFO, push and pop in the same cycle → count stays 16, no new overflow.
- `num_cycles`=0 → straight to CHECK; `done` after 32 cycles. `reset_n`=0 mid-CHECK → IDLE, `busy`=0, `err_count`=0; the next run still uses the previously loaded table.
- Build without `REGCHK_TRACE_EN` → `trace_valid` stays 0 under writes; pass/fail results are identical to the first scenario.
